// File: rtl/mbed_tester_peripheral_switch_apb2_slave_pkg.sv
// Shared definitions for the peripheral switch: register offsets, FSM encoding, status layout.
package mbed_tester_peripheral_switch_apb2_slave_pkg;

  localparam int unsigned REG_SEL       = 'h000;
  localparam int unsigned REG_STATUS    = 'h001;
  localparam int unsigned REG_ACTIVE    = 'h002;
  localparam int unsigned REG_GUARD     = 'h003;
  localparam int unsigned REG_SWCNT     = 'h004;
  localparam int unsigned REG_CONT_BASE = 'h010;

  // Depth of the logical_in synchroniser and of the matching val/drive delay line.
  localparam int unsigned SYNC_STAGES = 2;

  typedef enum logic {
    ST_ACTIVE = 1'b0,
    ST_GUARD  = 1'b1
  } sw_state_e;

  typedef struct packed {
    logic [5:0] rsvd;
    logic       idx_invalid;
    logic       guard_busy;
  } status_t;

endpackage

// File: rtl/mbed_tester_peripheral_switch_apb2_slave_if.sv
// APB2 config bus between the address decoder (master) and the peripheral switch (slave).
interface mbed_tester_peripheral_switch_apb2_slave_if #(
  parameter int unsigned ADDR_LOW_BITS = 12,
  parameter int unsigned DATA_BITS     = 8
);
  logic [ADDR_LOW_BITS-1:0] PADDR;
  logic                     PSEL;
  logic                     PENABLE;
  logic                     PWRITE;
  logic [DATA_BITS-1:0]     PWDATA;
  logic [DATA_BITS-1:0]     PRDATA;

  modport master (output PADDR, PSEL, PENABLE, PWRITE, PWDATA, input PRDATA);
  modport slave  (input PADDR, PSEL, PENABLE, PWRITE, PWDATA, output PRDATA);
endinterface

// File: rtl/mbed_tester_peripheral_switch_apb2_slave_io_contention_monitor.sv
// Sticky per-pin detector for a driven pin whose synchronised readback disagrees with its val.
module mbed_tester_peripheral_switch_apb2_slave_io_contention_monitor
  import mbed_tester_peripheral_switch_apb2_slave_pkg::*;
#(
  parameter int unsigned IO_LOGICAL = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IO_LOGICAL-1:0] pin_in,
  input  logic [IO_LOGICAL-1:0] routed_val,
  input  logic [IO_LOGICAL-1:0] routed_drive,
  input  logic                  route_active,
  input  logic [IO_LOGICAL-1:0] clear_mask,
  output logic [IO_LOGICAL-1:0] contention
);

  localparam int unsigned MW = $clog2(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][IO_LOGICAL-1:0] sync_q;
  logic [SYNC_STAGES-1:0][IO_LOGICAL-1:0] val_q;
  logic [SYNC_STAGES-1:0][IO_LOGICAL-1:0] drive_q;
  logic [MW-1:0]                          mask_cnt;
  logic [IO_LOGICAL-1:0]                  hit_c;

  // Synchronise readback and delay val/drive by the same number of stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      val_q   <= '0;
      drive_q <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pin_in};
      val_q   <= {val_q[SYNC_STAGES-2:0], routed_val};
      drive_q <= {drive_q[SYNC_STAGES-2:0], routed_drive};
    end
  end

  // Blank detection while the pipeline still holds pre-switch samples.
  always_ff @(posedge clk) begin
    if (rst || !route_active) begin
      mask_cnt <= MW'(SYNC_STAGES);
    end else if (mask_cnt != '0) begin
      mask_cnt <= mask_cnt - MW'(1);
    end
  end

  // Mismatch on an aligned, driven pin.
  always_comb begin
    hit_c = '0;
    if (route_active && (mask_cnt == '0)) begin
      hit_c = drive_q[SYNC_STAGES-1] & (sync_q[SYNC_STAGES-1] ^ val_q[SYNC_STAGES-1]);
    end
  end

  // Sticky bits; a new hit wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      contention <= '0;
    end else begin
      contention <= (contention & ~clear_mask) | hit_c;
    end
  end

endmodule

// File: rtl/mbed_tester_peripheral_switch_apb2_slave.sv
// APB2 slave selecting the active tester peripheral, with break-before-make switching.
module mbed_tester_peripheral_switch_apb2_slave
  import mbed_tester_peripheral_switch_apb2_slave_pkg::*;
#(
  parameter int unsigned IO_LOGICAL    = 8,
  parameter int unsigned PERIPHERALS   = 8,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned ADDR_LOW_BITS = 12,
  parameter int unsigned GUARD_CYCLES  = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [IO_LOGICAL-1:0]             logical_in,
  input  logic [PERIPHERALS*IO_LOGICAL-1:0] periph_val,
  input  logic [PERIPHERALS*IO_LOGICAL-1:0] periph_drive,
  output logic [PERIPHERALS-1:0]            periph_enable,
  output logic [IO_LOGICAL-1:0]             logical_val,
  output logic [IO_LOGICAL-1:0]             logical_drive,
  mbed_tester_peripheral_switch_apb2_slave_if.slave apb
);

  sw_state_e              state_q, state_d;
  logic [DATA_BITS-1:0]   sel_q, active_q, active_d, guard_q, swcnt_q, cnt_q, cnt_d;
  logic                   commit_c;
  logic                   wr_c, rd_c, sel_wr_c, guard_wr_c, swcnt_wr_c;
  logic                   idx_valid_c;
  status_t                status_c;
  logic [DATA_BITS-1:0]   rdata_c;
  logic [IO_LOGICAL-1:0]  clear_mask_c;
  logic [IO_LOGICAL-1:0]  contention;

  assign wr_c        = apb.PSEL && apb.PWRITE && apb.PENABLE;
  assign rd_c        = apb.PSEL && !apb.PWRITE;
  assign sel_wr_c    = wr_c && (apb.PADDR == ADDR_LOW_BITS'(REG_SEL));
  assign guard_wr_c  = wr_c && (apb.PADDR == ADDR_LOW_BITS'(REG_GUARD));
  assign swcnt_wr_c  = wr_c && (apb.PADDR == ADDR_LOW_BITS'(REG_SWCNT));
  assign idx_valid_c = 32'(active_q) < PERIPHERALS;

  // FSM and switch-sequencing registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_ACTIVE;
      active_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next state: a new target (re)starts the guard; guard expiry commits the target.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    commit_c = 1'b0;
    case (state_q)
      ST_ACTIVE: begin
        if (sel_wr_c && (apb.PWDATA != active_q)) begin
          state_d = ST_GUARD;
          cnt_d   = guard_q;
        end
      end
      ST_GUARD: begin
        if (sel_wr_c && (apb.PWDATA != sel_q)) begin
          cnt_d = guard_q;
        end else if (cnt_q == '0) begin
          state_d  = ST_ACTIVE;
          active_d = sel_q;
          commit_c = 1'b1;
        end else begin
          cnt_d = cnt_q - DATA_BITS'(1);
        end
      end
      default: state_d = ST_ACTIVE;
    endcase
  end

  // Software-owned SEL and GUARD registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q   <= '0;
      guard_q <= DATA_BITS'(GUARD_CYCLES);
    end else begin
      if (sel_wr_c)   sel_q   <= apb.PWDATA;
      if (guard_wr_c) guard_q <= apb.PWDATA;
    end
  end

  // Saturating count of completed switches; any write clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      swcnt_q <= '0;
    end else if (swcnt_wr_c) begin
      swcnt_q <= '0;
    end else if (commit_c && (swcnt_q != '1)) begin
      swcnt_q <= swcnt_q + DATA_BITS'(1);
    end
  end

  // Route the committed slot; everything released during guard or for an invalid slot.
  always_comb begin
    logical_val   = '0;
    logical_drive = '0;
    periph_enable = '0;
    if (state_q == ST_ACTIVE) begin
      for (int unsigned k = 0; k < PERIPHERALS; k++) begin
        if (active_q == DATA_BITS'(k)) begin
          logical_val      = periph_val[k*IO_LOGICAL +: IO_LOGICAL];
          logical_drive    = periph_drive[k*IO_LOGICAL +: IO_LOGICAL];
          periph_enable[k] = 1'b1;
        end
      end
    end
  end

  // Per-pin W1C strobes for the contention byte registers.
  always_comb begin
    clear_mask_c = '0;
    for (int unsigned i = 0; i < IO_LOGICAL; i++) begin
      if (wr_c && (apb.PADDR == ADDR_LOW_BITS'(REG_CONT_BASE + i / 8))) begin
        clear_mask_c[i] = apb.PWDATA[i % 8];
      end
    end
  end

  mbed_tester_peripheral_switch_apb2_slave_io_contention_monitor #(
    .IO_LOGICAL (IO_LOGICAL)
  ) u_contention (
    .clk          (clk),
    .rst          (rst),
    .pin_in       (logical_in),
    .routed_val   (logical_val),
    .routed_drive (logical_drive),
    .route_active (state_q == ST_ACTIVE),
    .clear_mask   (clear_mask_c),
    .contention   (contention)
  );

  // Read mux; unmapped offsets return zero.
  always_comb begin
    status_c             = '0;
    status_c.guard_busy  = (state_q == ST_GUARD);
    status_c.idx_invalid = !idx_valid_c;
    rdata_c              = '0;
    if (apb.PADDR == ADDR_LOW_BITS'(REG_SEL))    rdata_c = sel_q;
    if (apb.PADDR == ADDR_LOW_BITS'(REG_STATUS)) rdata_c = DATA_BITS'(status_c);
    if (apb.PADDR == ADDR_LOW_BITS'(REG_ACTIVE)) rdata_c = active_q;
    if (apb.PADDR == ADDR_LOW_BITS'(REG_GUARD))  rdata_c = guard_q;
    if (apb.PADDR == ADDR_LOW_BITS'(REG_SWCNT))  rdata_c = swcnt_q;
    for (int unsigned i = 0; i < IO_LOGICAL; i++) begin
      if (apb.PADDR == ADDR_LOW_BITS'(REG_CONT_BASE + i / 8)) begin
        rdata_c[i % 8] = contention[i];
      end
    end
  end

  // Registered read data, captured on every read-select cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      apb.PRDATA <= '0;
    end else if (rd_c) begin
      apb.PRDATA <= rdata_c;
    end
  end

endmodule

// File: tb/tb_mbed_tester_peripheral_switch_apb2_slave.sv
// Self-checking bench: APB op table with read scoreboard, plus hand-timed guard/reset sequences.
module tb_mbed_tester_peripheral_switch_apb2_slave;

  localparam int unsigned IO = 8;
  localparam int unsigned NP = 8;

  typedef enum {K_WR, K_RD, K_END} kind_e;
  typedef struct {
    kind_e       kind;
    logic [11:0] addr;
    logic [7:0]  data;
    string       name;
  } vec_t;
  typedef struct {
    string      name;
    logic [7:0] data;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [IO-1:0]        logical_in, logical_val, logical_drive, flip;
  logic [NP*IO-1:0]     periph_val, periph_drive;
  logic [NP-1:0]        periph_enable;

  vec_t vec[$];
  exp_t sb[$];
  int   vi = 0;
  int   checks = 0;
  int   errors = 0;

  mbed_tester_peripheral_switch_apb2_slave_if #(.ADDR_LOW_BITS(12), .DATA_BITS(8)) apb ();

  mbed_tester_peripheral_switch_apb2_slave #(
    .IO_LOGICAL(IO), .PERIPHERALS(NP), .DATA_BITS(8), .ADDR_LOW_BITS(12), .GUARD_CYCLES(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .logical_in    (logical_in),
    .periph_val    (periph_val),
    .periph_drive  (periph_drive),
    .periph_enable (periph_enable),
    .logical_val   (logical_val),
    .logical_drive (logical_drive),
    .apb           (apb)
  );

  always #5 clk = ~clk;

  // Pins read back what is routed, except where flip forces a disagreement.
  assign logical_in = logical_val ^ flip;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void w(input logic [11:0] a, input logic [7:0] d);
    vec.push_back('{K_WR, a, d, "wr"});
  endfunction
  function automatic void r(input logic [11:0] a, input logic [7:0] e, input string n);
    vec.push_back('{K_RD, a, e, n});
  endfunction
  function automatic void stop();
    vec.push_back('{K_END, 12'h0, 8'h0, ""});
  endfunction

  // One APB transfer; returns at the negedge just after the access-phase edge.
  task automatic apb_xfer(input bit wr, input logic [11:0] a, input logic [7:0] d, input string n);
    exp_t e;
    @(negedge clk);
    apb.PADDR   = a;
    apb.PWRITE  = wr;
    apb.PWDATA  = wr ? d : 8'h00;
    apb.PSEL    = 1'b1;
    apb.PENABLE = 1'b0;
    if (!wr) sb.push_back('{n, d});
    @(negedge clk);
    apb.PENABLE = 1'b1;
    @(negedge clk);
    apb.PSEL    = 1'b0;
    apb.PENABLE = 1'b0;
    if (!wr) begin
      e = sb.pop_front();
      check(e.name, apb.PRDATA, e.data);
    end
  endtask

  task automatic run_vec();
    while (vi < vec.size() && vec[vi].kind != K_END) begin
      apb_xfer(vec[vi].kind == K_WR, vec[vi].addr, vec[vi].data, vec[vi].name);
      vi++;
    end
    vi++;
  endtask

  // Expect 5 released cycles (GUARD=4) starting at the current negedge.
  task automatic check_guard(input string n);
    for (int i = 0; i < 5; i++) begin
      check({n, "_drive"}, logical_drive, 8'h00);
      check({n, "_val"}, logical_val, 8'h00);
      check({n, "_en"}, periph_enable, 8'h00);
      @(negedge clk);
    end
  endtask

  initial begin
    // Segment A: reset values and unmapped reads, then start switch to slot 3
    r(12'h000, 8'h00, "sel_rst");  r(12'h002, 8'h00, "active_rst");
    r(12'h003, 8'h04, "guard_rst"); r(12'h004, 8'h00, "swcnt_rst");
    r(12'h001, 8'h00, "status_rst"); r(12'h010, 8'h00, "cont_rst");
    r(12'h011, 8'h00, "unmapped_011"); r(12'h020, 8'h00, "unmapped_020");
    w(12'h000, 8'h03); stop();
    // B
    r(12'h004, 8'h01, "swcnt_sw3"); r(12'h002, 8'h03, "active_3");
    r(12'h001, 8'h00, "status_idle"); w(12'h000, 8'h02); stop();
    // C
    r(12'h004, 8'h02, "swcnt_restart_once"); r(12'h002, 8'h05, "active_5");
    w(12'h000, 8'h05); stop();
    // D
    r(12'h001, 8'h00, "status_same_sel"); r(12'h004, 8'h02, "swcnt_same_sel");
    w(12'h003, 8'h00); r(12'h003, 8'h00, "guard_zero"); w(12'h000, 8'h09); stop();
    // E
    r(12'h001, 8'h02, "status_invalid"); r(12'h002, 8'h09, "active_9");
    r(12'h004, 8'h03, "swcnt_invalid"); stop();
    // F
    w(12'h000, 8'h03); stop();
    // G
    r(12'h004, 8'h04, "swcnt_4"); r(12'h010, 8'h00, "cont_clean"); stop();
    // H
    r(12'h010, 8'h04, "cont_set"); w(12'h010, 8'h04); r(12'h010, 8'h04, "cont_set_wins"); stop();
    // I
    w(12'h010, 8'h04); r(12'h010, 8'h00, "cont_cleared"); stop();
    // J
    r(12'h010, 8'h04, "cont_preset"); w(12'h003, 8'h07); w(12'h000, 8'h02); stop();
    // K
    r(12'h000, 8'h00, "sel_after_rst"); r(12'h002, 8'h00, "active_after_rst");
    r(12'h004, 8'h00, "swcnt_after_rst"); r(12'h001, 8'h00, "status_after_rst");
    r(12'h003, 8'h04, "guard_after_rst"); r(12'h010, 8'h00, "cont_after_rst"); stop();
    // L
    w(12'h000, 8'h03); stop();
    // M
    r(12'h004, 8'h01, "swcnt_pre_clear"); w(12'h004, 8'hAA);
    r(12'h004, 8'h00, "swcnt_cleared"); r(12'h002, 8'h03, "active_final"); stop();

    periph_val   = '0;
    periph_drive = '0;
    for (int k = 1; k < NP; k++) periph_val[k*IO +: IO] = 8'(k * 'h11);
    periph_val[2*IO +: IO] = 8'hC3; periph_drive[2*IO +: IO] = 8'hF0;
    periph_val[3*IO +: IO] = 8'hA5; periph_drive[3*IO +: IO] = 8'hFF;
    periph_val[5*IO +: IO] = 8'h5A; periph_drive[5*IO +: IO] = 8'h0F;
    flip = '0;
    apb.PADDR = '0; apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PWDATA = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("prdata_rst", apb.PRDATA, 8'h00);
    check("enable_rst", periph_enable, 8'h01);
    check("drive_rst", logical_drive, 8'h00);

    // Test 1/2: reset registers, then SEL=3 with 5 released cycles
    run_vec();
    check_guard("sw3_guard");
    check("sw3_val", logical_val, 8'hA5);
    check("sw3_drive", logical_drive, 8'hFF);
    check("sw3_en", periph_enable, 8'h08);

    // Test 3: SEL=2 then SEL=5 mid-guard restarts the guard
    run_vec();
    apb_xfer(1'b1, 12'h000, 8'h05, "wr");
    check_guard("restart_guard");
    check("sw5_val", logical_val, 8'h5A);
    check("sw5_drive", logical_drive, 8'h0F);
    check("sw5_en", periph_enable, 8'h20);
    run_vec();
    check("same_sel_drive", logical_drive, 8'h0F);
    check("same_sel_en", periph_enable, 8'h20);

    // Test 4: GUARD=0, switch to invalid slot 9
    run_vec();
    check("sw9_guard_drive", logical_drive, 8'h00);
    run_vec();
    check("sw9_val", logical_val, 8'h00);
    check("sw9_drive", logical_drive, 8'h00);
    check("sw9_en", periph_enable, 8'h00);

    // GUARD=0: exactly one released cycle on the way back to slot 3
    run_vec();
    check("g0_released", logical_drive, 8'h00);
    @(negedge clk);
    check("g0_drive", logical_drive, 8'hFF);
    check("g0_en", periph_enable, 8'h08);

    // Test 5: contention on pin 2
    run_vec();
    flip = 8'h04;
    repeat (4) @(negedge clk);
    run_vec();
    flip = 8'h00;
    repeat (4) @(negedge clk);
    run_vec();

    // Test 6: reset during a guard interval
    flip = 8'h04;
    repeat (4) @(negedge clk);
    run_vec();
    check("pre_rst_in_guard", periph_enable, 8'h00);
    rst  = 1'b1;
    flip = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_en", periph_enable, 8'h01);
    check("rst_mid_drive", logical_drive, 8'h00);
    check("rst_mid_prdata", apb.PRDATA, 8'h00);
    run_vec();
    repeat (8) @(negedge clk);
    check("no_pending_switch", periph_enable, 8'h01);

    // SWCNT clear-on-write after one fresh switch
    run_vec();
    repeat (8) @(negedge clk);
    check("final_drive", logical_drive, 8'hFF);
    run_vec();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mbed_tester_peripheral_switch_apb2_slave.md
Name: mbed_tester_peripheral_switch_apb2_slave

Overview:
Parametrised successor to the tester's fixed 8-slot peripheral mux. It is an APB2 config slave that owns selection of the active tester peripheral and routes that peripheral's val/drive onto the logical IO bus. Switching is break-before-make: drive is released for a programmable guard interval on every switch. It adds a switch counter and per-pin sticky drive-contention detection. It sits between the APB2 address decoder and the logical-to-physical IO mux.

Parameters:
IO_LOGICAL, 8, logical IO pin count (1..64)
PERIPHERALS, 8, peripheral slot count (1..255)
DATA_BITS, 8, APB data width (fixed 8)
ADDR_LOW_BITS, 12, APB offset width inside this slave
GUARD_CYCLES, 4, reset value of GUARD register (0..255)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
logical_in  in  IO_LOGICAL  pin readback, asynchronous to clk
periph_val  in  PERIPHERALS*IO_LOGICAL  slot k val at [k*IO_LOGICAL+:IO_LOGICAL]
periph_drive  in  PERIPHERALS*IO_LOGICAL  slot k drive, same packing
periph_enable  out  PERIPHERALS  one-hot, active slot, state ACTIVE only
logical_val  out  IO_LOGICAL  routed val
logical_drive  out  IO_LOGICAL  routed drive
PADDR  in  ADDR_LOW_BITS  register offset
PSEL  in  1  slave select
PENABLE  in  1  access phase
PWRITE  in  1  write
PWDATA  in  DATA_BITS  write data
PRDATA  out  DATA_BITS  registered read data

Behaviour:
- Reset (clk, rst synchronous active-high): state ACTIVE, SEL=0, active=0, GUARD=GUARD_CYCLES, SWCNT=0, contention=0, PRDATA=0. logical_val, logical_drive and periph_enable take slot 0 routing (slot 0 is tied to zero by the integrator).
- Writes commit when PSEL&&PWRITE&&PENABLE.
- Reads register PRDATA on any cycle with PSEL&&!PWRITE; PRDATA holds otherwise. Unmapped offsets read 0.
- Register map:
  - 0x000 SEL: RW, requested slot.
  - 0x001 STATUS: RO; bit0=GUARD busy, bit1=active index invalid (>=PERIPHERALS).
  - 0x002 ACTIVE: RO, committed slot.
  - 0x003 GUARD: RW, guard length in cycles.
  - 0x004 SWCNT: RO, completed switches, saturates at 0xFF; a write of any value clears it.
  - 0x010+k: contention bits [8k+7:8k], W1C, for k < ceil(IO_LOGICAL/8).
- FSM ACTIVE→GUARD: on SEL write with value != active (and != target if already in GUARD). Load counter=GUARD.
  - In GUARD: logical_val=0, logical_drive=0, periph_enable=0. Counter decrements each cycle.
  - When counter==0 on a GUARD cycle: active<=SEL, SWCNT++, go to ACTIVE next cycle. GUARD=0 therefore gives exactly 1 released cycle.
- SEL write during GUARD with a new value restarts the counter from GUARD. A write of the current target does not restart.
- SEL write equal to active while ACTIVE: no state change, SWCNT unchanged.
- Active index >= PERIPHERALS: outputs all 0, periph_enable=0, STATUS.bit1=1. The switch still counts.
- Routing in ACTIVE is combinational from the periph_* inputs through a registered index (0-cycle data latency).
- Contention:
  - logical_in passes through a 2-flop synchroniser; logical_val/logical_drive are delayed 2 cycles to align.
  - Bit i sets when state ACTIVE, aligned drive[i]=1 and sync_in[i] != aligned val[i].
  - Masked for 2 cycles after entering ACTIVE.
  - Set wins over a simultaneous W1C.
- Reset mid-GUARD: returns immediately to reset state; no pending switch survives.

Decomposition:
- Shared package: register offsets (SEL, STATUS, ACTIVE, GUARD, SWCNT, CONT_BASE), state encoding ACTIVE/GUARD, SYNC_STAGES=2.
- One sub-module: io_contention_monitor (synchroniser, alignment delay, sticky bits, W1C port), parametrised by IO_LOGICAL.

Test Plan:
1. Reset, read 0x000/0x002/0x003/0x004 → 0,0,GUARD_CYCLES=4,0. logical_drive=0.
2. Slot3 drive=0xFF val=0xA5; write SEL=3 → drive=0 for exactly 5 cycles after the PENABLE write cycle, then val=0xA5, drive=0xFF, periph_enable=0x08, SWCNT=1.
3. Write SEL=2, then SEL=5 two cycles later with GUARD=4 → guard restarts, ends on slot 5, SWCNT increments by 1 only. Write SEL=5 again → no guard, SWCNT unchanged.
4. Write GUARD=0, SEL=9 with PERIPHERALS=8 → 1 released cycle, outputs 0, STATUS=0x02, ACTIVE=9.
5. Active slot drives pin 2 val=1, logical_in[2] forced 0 → 0x010 reads 0x04 within 4 cycles. Write 0x04 to 0x010 while the mismatch persists → remains 0x04. Remove the mismatch and clear → 0x00.
6. Assert rst during GUARD → next cycle state ACTIVE, ACTIVE=0, SWCNT=0, contention=0.
